// File: rtl/zbt_image_pkg.sv
// Shared ZBT frame-buffer definitions used by both the image writer and reader,
// so the byte packing order inside a 36-bit ZBT word has a single definition.
package zbt_image_pkg;

  localparam int ZBT_DATA_WIDTH = 36;
  localparam int PIXEL_WIDTH    = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int PAYLOAD_WIDTH  = PIXEL_WIDTH * BYTES_PER_WORD;

  // First pixel of a word lives in the most significant payload byte.
  localparam int BYTE0_MSB = 31;
  localparam int BYTE1_MSB = 23;
  localparam int BYTE2_MSB = 15;
  localparam int BYTE3_MSB = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SERVE = 2'd2
  } reader_state_t;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;

  function automatic logic [PIXEL_WIDTH-1:0] byte_lane(
    input logic [PAYLOAD_WIDTH-1:0] word,
    input byte_idx_t                idx
  );
    byte_lane = word[BYTE0_MSB -: PIXEL_WIDTH];
    case (idx)
      2'd0:    byte_lane = word[BYTE0_MSB -: PIXEL_WIDTH];
      2'd1:    byte_lane = word[BYTE1_MSB -: PIXEL_WIDTH];
      2'd2:    byte_lane = word[BYTE2_MSB -: PIXEL_WIDTH];
      default: byte_lane = word[BYTE3_MSB -: PIXEL_WIDTH];
    endcase
  endfunction

endpackage

// File: rtl/zbt_word_unpacker.sv
// Holds one ZBT word and presents its four pixels in order on a registered
// pixel_data output; the FSM in the top level decides when to load and advance.
module zbt_word_unpacker
  import zbt_image_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      advance,
  input  logic [ZBT_DATA_WIDTH-1:0] read_word,
  output logic [PIXEL_WIDTH-1:0]    pixel_data,
  output logic                      last_byte
);

  logic [PAYLOAD_WIDTH-1:0] held_word;
  byte_idx_t                byte_idx;
  byte_idx_t                next_idx;

  // The top nibble of a ZBT word carries no pixel data.
  logic unused_tag_bits;
  assign unused_tag_bits = ^read_word[ZBT_DATA_WIDTH-1:PAYLOAD_WIDTH];

  assign next_idx  = byte_idx + byte_idx_t'(1);
  assign last_byte = (byte_idx == byte_idx_t'(BYTES_PER_WORD - 1));

  // pixel_data is registered from the next lane so it lines up with byte_idx;
  // after the last byte it simply holds until the next word is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_word  <= '0;
      byte_idx   <= '0;
      pixel_data <= '0;
    end else if (load) begin
      held_word  <= read_word[PAYLOAD_WIDTH-1:0];
      byte_idx   <= '0;
      pixel_data <= byte_lane(read_word[PAYLOAD_WIDTH-1:0], byte_idx_t'(0));
    end else if (advance && !last_byte) begin
      byte_idx   <= next_idx;
      pixel_data <= byte_lane(held_word, next_idx);
    end
  end

endmodule

// File: rtl/zbt_image_reader.sv
// Walks a frame stored in ZBT SRAM word by word, waits out the fixed read
// latency, and streams the unpacked pixels over a valid/request handshake.
module zbt_image_reader
  import zbt_image_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 19,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    NUM_WORDS    = 76800,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pixel_req,
  input  logic [ZBT_DATA_WIDTH-1:0] zbt_read_data,
  output logic [ADDR_WIDTH-1:0]     zbt_addr,
  output logic                      zbt_re,
  output logic [PIXEL_WIDTH-1:0]    pixel_data,
  output logic                      pixel_valid,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int COUNT_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LAT_WIDTH   = $clog2(READ_LATENCY + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_WORD = COUNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [LAT_WIDTH-1:0]   LAT_DONE  = LAT_WIDTH'(READ_LATENCY);

  reader_state_t          state, state_n;
  logic [COUNT_WIDTH-1:0] word_cnt, word_cnt_n;
  logic [LAT_WIDTH-1:0]   lat_cnt, lat_cnt_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic                   re_n, valid_n, done_n, busy_n;
  logic                   load_word, transfer, last_byte;

  assign transfer = pixel_valid && pixel_req;

  zbt_word_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (load_word),
    .advance    (transfer),
    .read_word  (zbt_read_data),
    .pixel_data (pixel_data),
    .last_byte  (last_byte)
  );

  // Next-state logic; every output is registered from these *_n values.
  // frame_done marks the first IDLE cycle, so start is refused there.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    lat_cnt_n  = lat_cnt;
    addr_n     = zbt_addr;
    re_n       = 1'b0;
    valid_n    = pixel_valid;
    done_n     = 1'b0;
    busy_n     = busy;
    load_word  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !frame_done) begin
          state_n    = FETCH;
          busy_n     = 1'b1;
          word_cnt_n = '0;
          lat_cnt_n  = '0;
          addr_n     = BASE_ADDR;
          re_n       = 1'b1;
        end
      end
      FETCH: begin
        if (lat_cnt == LAT_DONE) begin
          load_word = 1'b1;
          valid_n   = 1'b1;
          state_n   = SERVE;
        end else begin
          lat_cnt_n = lat_cnt + LAT_WIDTH'(1);
        end
      end
      SERVE: begin
        if (transfer && last_byte) begin
          valid_n = 1'b0;
          if (word_cnt == LAST_WORD) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            word_cnt_n = word_cnt + COUNT_WIDTH'(1);
            addr_n     = BASE_ADDR + ADDR_WIDTH'(word_cnt_n);
            re_n       = 1'b1;
            lat_cnt_n  = '0;
            state_n    = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_cnt    <= '0;
      lat_cnt     <= '0;
      zbt_addr    <= BASE_ADDR;
      zbt_re      <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      word_cnt    <= word_cnt_n;
      lat_cnt     <= lat_cnt_n;
      zbt_addr    <= addr_n;
      zbt_re      <= re_n;
      pixel_valid <= valid_n;
      frame_done  <= done_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_zbt_image_reader.sv
// Directed bench for zbt_image_reader: a one-word frame and a three-word frame
// instance, each fed by a small latency-accurate ZBT read model.
module tb_zbt_image_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_1, req_1, re_1, valid_1, done_1, busy_1;
  logic [18:0] addr_1;
  logic [7:0]  data_1;
  logic [35:0] rdata_1;

  logic        start_3, req_3, re_3, valid_3, done_3, busy_3;
  logic [18:0] addr_3;
  logic [7:0]  data_3;
  logic [35:0] rdata_3;

  zbt_image_reader #(
    .ADDR_WIDTH(19), .BASE_ADDR(19'h0), .NUM_WORDS(1), .READ_LATENCY(2)
  ) u_single (
    .clk(clk), .reset(reset), .start(start_1), .pixel_req(req_1),
    .zbt_read_data(rdata_1), .zbt_addr(addr_1), .zbt_re(re_1),
    .pixel_data(data_1), .pixel_valid(valid_1), .frame_done(done_1), .busy(busy_1)
  );

  zbt_image_reader #(
    .ADDR_WIDTH(19), .BASE_ADDR(19'h100), .NUM_WORDS(3), .READ_LATENCY(2)
  ) u_multi (
    .clk(clk), .reset(reset), .start(start_3), .pixel_req(req_3),
    .zbt_read_data(rdata_3), .zbt_addr(addr_3), .zbt_re(re_3),
    .pixel_data(data_3), .pixel_valid(valid_3), .frame_done(done_3), .busy(busy_3)
  );

  // ZBT model: data for a read strobed in cycle c is present in cycle c+2.
  logic        s0_re_1 = 1'b0, s1_re_1 = 1'b0, s0_re_3 = 1'b0, s1_re_3 = 1'b0;
  logic [18:0] s0_addr_3 = '0, s1_addr_3 = '0;

  function automatic logic [35:0] mem_word(input logic [18:0] a);
    case (a)
      19'h100: mem_word = 36'h011223344;
      19'h101: mem_word = 36'h055667788;
      19'h102: mem_word = 36'h099AABBCC;
      default: mem_word = 36'hEEEEEEEEE;
    endcase
  endfunction

  always @(posedge clk) begin
    s0_re_1   <= re_1;
    s1_re_1   <= s0_re_1;
    s0_re_3   <= re_3;
    s1_re_3   <= s0_re_3;
    s0_addr_3 <= addr_3;
    s1_addr_3 <= s0_addr_3;
  end

  assign rdata_1 = s1_re_1 ? 36'hFAABBCCDD : 36'h313131313;
  assign rdata_3 = s1_re_3 ? mem_word(s1_addr_3) : 36'h313131313;

  logic [7:0]  pix_1[$];
  logic [7:0]  pix_3[$];
  logic [18:0] addr_q_3[$];
  int re_count_1 = 0, re_count_3 = 0, done_count_1 = 0, done_count_3 = 0;

  // Mid-cycle monitors record strobes, completed transfers and frame_done pulses.
  always @(negedge clk) begin
    if (re_1) re_count_1++;
    if (done_1) done_count_1++;
    if (valid_1 && req_1) pix_1.push_back(data_1);
    if (re_3) begin
      re_count_3++;
      addr_q_3.push_back(addr_3);
    end
    if (done_3) done_count_3++;
    if (valid_3 && req_3) pix_3.push_back(data_3);
  end

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] single_exp[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] bp_exp[7]     = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD};
  logic [6:0] bp_req        = 7'b1101001;
  logic [7:0] multi_exp[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    int n;
    int re_before;
    int done_before;
    reset = 1'b1;
    start_1 = 1'b0; req_1 = 1'b0; start_3 = 1'b0; req_3 = 1'b0;
    repeat (3) step_cycle();
    reset = 1'b0;

    // Reset values, then ten idle cycles with no read strobe.
    checkOutput("rst_addr1", 64'(addr_1), 64'h0);
    checkOutput("rst_addr3", 64'(addr_3), 64'h100);
    checkOutput("rst_re", 64'(re_1), 64'd0);
    checkOutput("rst_data", 64'(data_1), 64'h0);
    checkOutput("rst_valid", 64'(valid_1), 64'd0);
    checkOutput("rst_done", 64'(done_1), 64'd0);
    checkOutput("rst_busy", 64'(busy_3), 64'd0);
    repeat (10) step_cycle();
    checkOutput("idle_re_count", 64'(re_count_1 + re_count_3), 64'd0);

    // Single word, request held high: pixels in cycles 4..7, done in cycle 8.
    re_before = re_count_1;
    pix_1.delete();
    req_1 = 1'b1;
    start_1 = 1'b1;
    step_cycle();
    start_1 = 1'b0;
    checkOutput("s_busy", 64'(busy_1), 64'd1);
    checkOutput("s_re", 64'(re_1), 64'd1);
    checkOutput("s_addr", 64'(addr_1), 64'h0);
    step_cycle();
    checkOutput("s_re_drop", 64'(re_1), 64'd0);
    step_cycle();
    checkOutput("s_valid_c3", 64'(valid_1), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput("s_valid", 64'(valid_1), 64'd1);
      checkOutput("s_pix", 64'(data_1), 64'(single_exp[i]));
    end
    step_cycle();
    checkOutput("s_done", 64'(done_1), 64'd1);
    checkOutput("s_done_busy", 64'(busy_1), 64'd0);
    checkOutput("s_done_valid", 64'(valid_1), 64'd0);
    step_cycle();
    checkOutput("s_done_pulse", 64'(done_1), 64'd0);
    checkOutput("s_re_count", 64'(re_count_1 - re_before), 64'd1);
    checkOutput("s_pix_count", 64'(pix_1.size()), 64'd4);
    req_1 = 1'b0;

    // Back-pressure: request pattern 1,0,0,1,0,1,1 from the first valid cycle.
    pix_1.delete();
    start_1 = 1'b1;
    step_cycle();
    start_1 = 1'b0;
    n = 0;
    while (!valid_1 && n < 20) begin
      step_cycle();
      n++;
    end
    checkOutput("bp_valid_rise", 64'(valid_1), 64'd1);
    for (int i = 0; i < 7; i++) begin
      req_1 = bp_req[i];
      checkOutput("bp_valid", 64'(valid_1), 64'd1);
      checkOutput("bp_pix", 64'(data_1), 64'(bp_exp[i]));
      step_cycle();
    end
    req_1 = 1'b0;
    checkOutput("bp_done", 64'(done_1), 64'd1);
    checkOutput("bp_pix_count", 64'(pix_1.size()), 64'd4);
    for (int i = 0; i < 4 && i < pix_1.size(); i++)
      checkOutput("bp_order", 64'(pix_1[i]), 64'(single_exp[i]));

    // Three words from 0x100 with stray starts in FETCH, SERVE and the done cycle.
    pix_3.delete();
    addr_q_3.delete();
    re_count_3 = 0;
    done_count_3 = 0;
    req_3 = 1'b1;
    start_3 = 1'b1;
    step_cycle();
    n = 1;
    while (!done_3 && n < 100) begin
      start_3 = (n == 2 || n == 6);
      step_cycle();
      n++;
    end
    checkOutput("m_done_seen", 64'(done_3), 64'd1);
    start_3 = 1'b1;
    step_cycle();
    start_3 = 1'b0;
    checkOutput("m_start_in_done_busy", 64'(busy_3), 64'd0);
    checkOutput("m_start_in_done_re", 64'(re_3), 64'd0);
    repeat (3) step_cycle();
    checkOutput("m_done_count", 64'(done_count_3), 64'd1);
    checkOutput("m_re_count", 64'(re_count_3), 64'd3);
    for (int i = 0; i < 3 && i < addr_q_3.size(); i++)
      checkOutput("m_addr", 64'(addr_q_3[i]), 64'(19'h100 + 19'(i)));
    checkOutput("m_pix_count", 64'(pix_3.size()), 64'd12);
    for (int i = 0; i < 12 && i < pix_3.size(); i++)
      checkOutput("m_pix", 64'(pix_3[i]), 64'(multi_exp[i]));

    // Reset after two pixels of the second word, then a clean restart.
    pix_3.delete();
    start_3 = 1'b1;
    step_cycle();
    start_3 = 1'b0;
    n = 0;
    while (pix_3.size() < 6 && n < 60) begin
      step_cycle();
      n++;
    end
    req_3 = 1'b0;
    checkOutput("r_mid_valid", 64'(valid_3), 64'd1);
    checkOutput("r_mid_pix", 64'(data_3), 64'h77);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    checkOutput("r_addr", 64'(addr_3), 64'h100);
    checkOutput("r_valid", 64'(valid_3), 64'd0);
    checkOutput("r_data", 64'(data_3), 64'h0);
    checkOutput("r_busy", 64'(busy_3), 64'd0);
    checkOutput("r_re", 64'(re_3), 64'd0);
    done_before = done_count_3;
    repeat (10) step_cycle();
    checkOutput("r_no_done", 64'(done_count_3 - done_before), 64'd0);
    pix_3.delete();
    addr_q_3.delete();
    req_3 = 1'b1;
    start_3 = 1'b1;
    step_cycle();
    start_3 = 1'b0;
    n = 0;
    while (!done_3 && n < 100) begin
      step_cycle();
      n++;
    end
    req_3 = 1'b0;
    checkOutput("r2_done_seen", 64'(done_3), 64'd1);
    checkOutput("r2_first_addr", 64'(addr_q_3.size() > 0 ? addr_q_3[0] : 19'h7FFFF), 64'h100);
    checkOutput("r2_first_pix", 64'(pix_3.size() > 0 ? pix_3[0] : 8'h00), 64'h11);
    checkOutput("r2_pix_count", 64'(pix_3.size()), 64'd12);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
